// File: rtl/alu_mc_unit.sv
// Registered, handshaked RV32 ALU with an iterative shift-add multiplier.
// Optional mulhu support is enabled by defining ALU_MULHU_EN.
module alu_mc_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [1:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
`ifdef ALU_MULHU_EN
  localparam int PW = 2 * XLEN;
`else
  localparam int PW = XLEN;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              branch_q, branch_d;
  logic              illegal_q, illegal_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic              hi_q, hi_d;

  logic [XLEN-1:0]   dec_res;
  logic              dec_br, dec_ill, dec_mul, dec_hi;
  logic [SHW-1:0]    shamt;
  logic              lt_s, lt_u, eq;
  logic [PW-1:0]     mul_sum;
  logic              accept;

  assign shamt   = op_b[SHW-1:0];
  assign lt_s    = $signed(op_a) < $signed(op_b);
  assign lt_u    = op_a < op_b;
  assign eq      = op_a == op_b;
  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign out_valid    = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign in_ready     = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept       = in_valid && in_ready;
  assign result       = result_q;
  assign branch_taken = branch_q;
  assign illegal      = illegal_q;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    dec_res = '0;
    dec_br  = 1'b0;
    dec_ill = 1'b0;
    dec_mul = 1'b0;
    dec_hi  = 1'b0;
    case (ALUOp)
      2'b01: begin
        dec_res = op_a - op_b;
        case (funct3)
          3'd0:    dec_br = eq;
          3'd1:    dec_br = !eq;
          3'd4:    dec_br = lt_s;
          3'd5:    dec_br = !lt_s;
          3'd6:    dec_br = lt_u;
          3'd7:    dec_br = !lt_u;
          default: dec_ill = 1'b1;
        endcase
      end
      2'b10: begin
        case ({funct7, funct3})
          5'b00000: dec_res = op_a + op_b;
          5'b10000: dec_res = op_a - op_b;
          5'b00100: dec_res = op_a ^ op_b;
          5'b00110: dec_res = op_a | op_b;
          5'b00111: dec_res = op_a & op_b;
          5'b00001: dec_res = op_a << shamt;
          5'b00101: dec_res = op_a >> shamt;
          5'b10101: dec_res = $signed(op_a) >>> shamt;
          5'b00010: dec_res = {{(XLEN-1){1'b0}}, lt_s};
          5'b00011: dec_res = {{(XLEN-1){1'b0}}, lt_u};
          5'b01000: dec_mul = 1'b1;
`ifdef ALU_MULHU_EN
          5'b01011: begin
            dec_mul = 1'b1;
            dec_hi  = 1'b1;
          end
`endif
          default:  dec_ill = 1'b1;
        endcase
      end
      default: dec_res = op_a + op_b;
    endcase
    // Illegal codes take the single-cycle path with cleared outputs.
    if (dec_ill) begin
      dec_res = '0;
      dec_br  = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    case (state_q)
      S_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(XLEN - 1)) begin
          state_d   = S_DONE;
          result_d  = hi_q ? mul_sum[PW-1 -: XLEN] : mul_sum[XLEN-1:0];
          branch_d  = 1'b0;
          illegal_d = 1'b0;
        end
      end
      default: begin
        if (state_q == S_DONE && out_ready && !in_valid) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          if (dec_mul) begin
            // Operands are captured so op_a/op_b may change during the iteration.
            state_d  = S_MUL;
            mcand_d  = PW'(op_a);
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
            hi_d     = dec_hi;
          end else begin
            state_d   = S_DONE;
            result_d  = dec_res;
            branch_d  = dec_br;
            illegal_d = dec_ill;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; all registers, including
  // the multiplier datapath, are reset so a discarded operation leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
    end
  end

endmodule

// File: tb/tb_alu_mc_unit.sv
// Self-checking bench for alu_mc_unit: transaction-level model plus directed
// vectors with literal expectations. Honours ALU_MULHU_EN like the design.
module tb_alu_mc_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      ALUOp = '0;
  logic [1:0]      funct7 = '0;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            branch_taken;
  logic            illegal;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_mc_unit #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ALUOp        (ALUOp),
    .funct7       (funct7),
    .funct3       (funct3),
    .op_a         (op_a),
    .op_b         (op_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .illegal      (illegal),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic [31:0] res;
    logic        br;
    logic        ill;
    logic        mul;
  } exp_t;

  // Architectural meaning of each operation, computed directly.
  function automatic exp_t model(input logic [1:0] aop, input logic [1:0] f7,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    int          sa;
    e  = '0;
    p  = {32'd0, a} * {32'd0, b};
    sa = int'(b % 32);
    if (aop == 2'b00 || aop == 2'b11) begin
      e.res = a + b;
    end else if (aop == 2'b01) begin
      e.res = a - b;
      case (f3)
        3'd0:    e.br = (a == b);
        3'd1:    e.br = (a != b);
        3'd4:    e.br = ($signed(a) < $signed(b));
        3'd5:    e.br = ($signed(a) >= $signed(b));
        3'd6:    e.br = (a < b);
        3'd7:    e.br = (a >= b);
        default: e.ill = 1'b1;
      endcase
    end else begin
      case ({f7, f3})
        5'b00000: e.res = a + b;
        5'b10000: e.res = a - b;
        5'b00100: e.res = a ^ b;
        5'b00110: e.res = a | b;
        5'b00111: e.res = a & b;
        5'b00001: e.res = a << sa;
        5'b00101: e.res = a >> sa;
        5'b10101: e.res = 32'($signed(a) >>> sa);
        5'b00010: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        5'b00011: e.res = (a < b) ? 32'd1 : 32'd0;
        5'b01000: begin e.res = p[31:0]; e.mul = 1'b1; end
`ifdef ALU_MULHU_EN
        5'b01011: begin e.res = p[63:32]; e.mul = 1'b1; end
`endif
        default:  e.ill = 1'b1;
      endcase
    end
    if (e.ill) begin
      e.res = '0;
      e.br  = 1'b0;
      e.mul = 1'b0;
    end
    return e;
  endfunction

  // Transaction-level timing model: single ops valid next cycle, mul after XLEN more.
  logic m_valid;
  int   m_wait;
  exp_t m_cur, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_wait  <= 0;
      m_cur   <= '0;
      m_pend  <= '0;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_valid <= 1'b1;
        m_cur   <= m_pend;
      end
    end else if (in_valid && (!m_valid || out_ready)) begin
      if (model(ALUOp, funct7, funct3, op_a, op_b).mul) begin
        m_valid <= 1'b0;
        m_wait  <= XLEN;
        m_pend  <= model(ALUOp, funct7, funct3, op_a, op_b);
      end else begin
        m_valid <= 1'b1;
        m_cur   <= model(ALUOp, funct7, funct3, op_a, op_b);
      end
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_out_valid", 32'(out_valid), 32'(m_valid));
      check("model_in_ready", 32'(in_ready), 32'((m_wait == 0) && (!m_valid || out_ready)));
      check("model_busy", 32'(busy), 32'(m_valid || (m_wait != 0)));
      if (m_valid) begin
        check("model_result", result, m_cur.res);
        check("model_branch", 32'(branch_taken), 32'(m_cur.br));
        check("model_illegal", 32'(illegal), 32'(m_cur.ill));
      end
    end
  end

  // Issue one op from idle with out_ready high; operands are scrambled after acceptance.
  task automatic do_op(input logic [1:0] aop, input logic [1:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic br, output logic il,
                       output int lat);
    ALUOp = aop; funct7 = f7; funct3 = f3; op_a = a; op_b = b;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    if (!out_valid) check("op_timeout", 32'(out_valid), 32'd1);
    r = result; br = branch_taken; il = illegal;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        br, il;
    int          lat;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {30'd0, branch_taken, illegal}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(2'b10, 2'b10, 3'd0, 32'd5, 32'd7, r, br, il, lat);
    check("sub_res", r, 32'hFFFF_FFFE);
    check("sub_lat", lat, 32'd1);
    check("sub_ill", 32'(il), 32'd0);

    do_op(2'b01, 2'b00, 3'd5, 32'hFFFF_FFFF, 32'd1, r, br, il, lat);
    check("bge_taken", 32'(br), 32'd0);
    check("bge_res", r, 32'hFFFF_FFFE);
    do_op(2'b01, 2'b00, 3'd7, 32'hFFFF_FFFF, 32'd1, r, br, il, lat);
    check("bgeu_taken", 32'(br), 32'd1);
    do_op(2'b01, 2'b00, 3'd4, 32'hFFFF_FFFF, 32'd1, r, br, il, lat);
    check("blt_taken", 32'(br), 32'd1);
    do_op(2'b01, 2'b00, 3'd6, 32'hFFFF_FFFF, 32'd1, r, br, il, lat);
    check("bltu_taken", 32'(br), 32'd0);
    do_op(2'b01, 2'b00, 3'd0, 32'd9, 32'd9, r, br, il, lat);
    check("beq_taken", 32'(br), 32'd1);
    do_op(2'b01, 2'b00, 3'd1, 32'd9, 32'd9, r, br, il, lat);
    check("bne_taken", 32'(br), 32'd0);
    do_op(2'b01, 2'b00, 3'd2, 32'd9, 32'd3, r, br, il, lat);
    check("br_f3_2_ill", {r[30:0], il}, 32'd1);

    do_op(2'b10, 2'b11, 3'd7, 32'd9, 32'd3, r, br, il, lat);
    check("ill_11111", {r[30:0], il}, 32'd1);
    check("ill_11111_hi", 32'(r[31]), 32'd0);

    do_op(2'b10, 2'b10, 3'd5, 32'h8000_0000, 32'h24, r, br, il, lat);
    check("sra_res", r, 32'hF800_0000);
    do_op(2'b10, 2'b00, 3'd1, 32'd1, 32'h3F, r, br, il, lat);
    check("sll_res", r, 32'h8000_0000);
    do_op(2'b10, 2'b00, 3'd5, 32'h8000_0000, 32'h23, r, br, il, lat);
    check("srl_res", r, 32'h1000_0000);
    do_op(2'b10, 2'b00, 3'd2, 32'hFFFF_FFFF, 32'd1, r, br, il, lat);
    check("slt_res", r, 32'd1);
    do_op(2'b10, 2'b00, 3'd3, 32'hFFFF_FFFF, 32'd1, r, br, il, lat);
    check("sltu_res", r, 32'd0);
    do_op(2'b10, 2'b00, 3'd6, 32'h0000_00F0, 32'h0000_000F, r, br, il, lat);
    check("or_res", r, 32'h0000_00FF);
    do_op(2'b11, 2'b11, 3'd7, 32'hFFFF_FFFF, 32'd2, r, br, il, lat);
    check("addi_res", r, 32'd1);
    do_op(2'b00, 2'b01, 3'd2, 32'h0000_1000, 32'h24, r, br, il, lat);
    check("ldst_res", r, 32'h0000_1024);

    do_op(2'b10, 2'b01, 3'd0, 32'h0001_0003, 32'h0000_0005, r, br, il, lat);
    check("mul_res", r, 32'h0005_000F);
    check("mul_lat", lat, 32'd33);
    do_op(2'b10, 2'b01, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, br, il, lat);
    check("mul_lo_ff", r, 32'd1);
    do_op(2'b10, 2'b01, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, br, il, lat);
`ifdef ALU_MULHU_EN
    check("mulhu_res", r, 32'hFFFF_FFFE);
    check("mulhu_lat", lat, 32'd33);
`else
    check("mulhu_ill", {r[30:0], il}, 32'd1);
    check("mulhu_lat", lat, 32'd1);
`endif

    // Back-to-back xor then add, then a held result with out_ready low.
    ALUOp = 2'b10; funct7 = 2'b00; funct3 = 3'd4;
    op_a = 32'hF0F0_1234; op_b = 32'h0FF0_4321;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    funct3 = 3'd0; op_a = 32'd100; op_b = 32'd23;
    @(negedge clk);
    check("b2b_xor_res", result, 32'hFF00_5115);
    check("b2b_xor_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    funct3 = 3'd7; op_a = 32'hFF00_FF00; op_b = 32'h0F0F_0F0F;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_res", result, 32'd123);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_and_res", result, 32'h0F00_0F00);
    @(posedge clk); #1;

    // Reset asserted during multiplier step 10.
    ALUOp = 2'b10; funct7 = 2'b01; funct3 = 3'd0;
    op_a = 32'h1234_5678; op_b = 32'h0000_0F0F;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_mul_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'd0);
    end
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
